// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - two-port arbiter in front of the single-port instruction ROM
//
// Purpose:
//   The CPU fetch port (F) and the debug read port (D) share one synchronous ROM.
//   This block chooses which port is served. It drives the registered ROM address
//   and waits ROM_LAT edges. It then captures rom_q_i and returns the word to the
//   granted port with a single-cycle ack.
//
// Ports:
//   clock_i        system clock, rising edge
//   reset_i        synchronous, active-high reset
//   f_req_i        fetch request, held until f_ack_o
//   f_addr_i       fetch word address
//   f_ack_o        one-cycle pulse, f_rdata_o valid
//   f_rdata_o      fetched word, held until the next f_ack_o
//   d_req_i        debug request, held until d_ack_o
//   d_addr_i       debug word address
//   d_ack_o        one-cycle pulse, d_rdata_o valid
//   d_rdata_o      debug word, held until the next d_ack_o
//   rom_address_o  registered ROM address
//   rom_q_i        ROM read data
//   busy_o         high whenever the FSM is outside IDLE
//   fetch_count_o  completed F transactions, wraps modulo 2^CW

module imem_fetch_arbiter #(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int ROM_LAT = 1,
    parameter int CW      = 16
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          f_req_i,
    input  logic [AW-1:0] f_addr_i,
    output logic          f_ack_o,
    output logic [DW-1:0] f_rdata_o,
    input  logic          d_req_i,
    input  logic [AW-1:0] d_addr_i,
    output logic          d_ack_o,
    output logic [DW-1:0] d_rdata_o,
    output logic [AW-1:0] rom_address_o,
    input  logic [DW-1:0] rom_q_i,
    output logic          busy_o,
    output logic [CW-1:0] fetch_count_o
);

    localparam int LW = $clog2(ROM_LAT + 1);

    localparam logic GNT_F = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          f_ack_q, f_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [CW-1:0] count_q, count_d;

    // A requester whose ack is high this cycle is not eligible. Its req is
    // still high during the ack cycle, and that level must not start a
    // second transaction.
    logic f_elig;
    logic d_elig;
    logic pick_f;

    assign f_elig = f_req_i & ~f_ack_q;
    assign d_elig = d_req_i & ~d_ack_q;
    // When both ports are eligible, F wins unless F had the previous grant.
    assign pick_f = f_elig & (~d_elig | (last_q == GNT_D));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            gnt_q     <= GNT_F;
            last_q    <= GNT_D;
            addr_q    <= '0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            f_ack_q   <= f_ack_d;
            d_ack_q   <= d_ack_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        f_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE: begin
                if (f_elig || d_elig) begin
                    // The address is latched here. Later changes on the
                    // request address inputs do not affect this transaction.
                    if (pick_f) begin
                        addr_d = f_addr_i;
                        gnt_d  = GNT_F;
                        last_d = GNT_F;
                    end else begin
                        addr_d = d_addr_i;
                        gnt_d  = GNT_D;
                        last_d = GNT_D;
                    end
                    cnt_d   = LW'(ROM_LAT);
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q - LW'(1);
                if (cnt_q == LW'(1)) begin
                    state_d = S_CAPT;
                end
            end

            S_CAPT: begin
                if (gnt_q == GNT_F) begin
                    f_rdata_d = rom_q_i;
                    f_ack_d   = 1'b1;
                    count_d   = count_q + CW'(1);
                end else begin
                    d_rdata_d = rom_q_i;
                    d_ack_d   = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign f_ack_o       = f_ack_q;
    assign d_ack_o       = d_ack_q;
    assign f_rdata_o     = f_rdata_q;
    assign d_rdata_o     = d_rdata_q;
    assign rom_address_o = addr_q;
    assign busy_o        = (state_q != S_IDLE);
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - scoreboard bench for imem_fetch_arbiter
module tb_imem_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [4:0]  f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        d_req;
    logic [4:0]  d_addr;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [4:0]  rom_address;
    logic [31:0] rom_q;
    logic        busy;
    logic [3:0]  fetch_count;

    logic [31:0] rom [32];
    logic [4:0]  rom_addr_reg;

    logic [31:0] fq[$];
    logic [31:0] dq[$];

    int n_tests = 0;
    int n_fail  = 0;
    logic f_ack_prev = 1'b0;
    logic d_ack_prev = 1'b0;

    always #5 clk = ~clk;

    imem_fetch_arbiter #(.AW(5), .DW(32), .ROM_LAT(1), .CW(4)) dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .f_req_i       (f_req),
        .f_addr_i      (f_addr),
        .f_ack_o       (f_ack),
        .f_rdata_o     (f_rdata),
        .d_req_i       (d_req),
        .d_addr_i      (d_addr),
        .d_ack_o       (d_ack),
        .d_rdata_o     (d_rdata),
        .rom_address_o (rom_address),
        .rom_q_i       (rom_q),
        .busy_o        (busy),
        .fetch_count_o (fetch_count)
    );

    // ROM model: the address is registered on the clock, and q is a combinational read of it.
    always @(posedge clk) rom_addr_reg <= rom_address;
    assign rom_q = rom[rom_addr_reg];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (f_ack) begin
            chk("f_expected", fq.size() != 0, 1);
            if (fq.size() != 0) chk("f_rdata", f_rdata, fq.pop_front());
            chk("f_ack_pulse", f_ack_prev, 0);
        end
        if (d_ack) begin
            chk("d_expected", dq.size() != 0, 1);
            if (dq.size() != 0) chk("d_rdata", d_rdata, dq.pop_front());
            chk("d_ack_pulse", d_ack_prev, 0);
        end
        if (f_ack || d_ack) chk("ack_excl", f_ack & d_ack, 0);
        f_ack_prev = f_ack;
        d_ack_prev = d_ack;
    end

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_f_ack(input int maxc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!f_ack && cyc < maxc);
        chk("f_ack_seen", f_ack, 1);
    endtask

    task automatic do_f(input logic [4:0] a);
        int cyc;
        @(negedge clk);
        f_addr = a;
        f_req  = 1'b1;
        fq.push_back(rom[a]);
        wait_f_ack(10, cyc);
        f_req = 1'b0;
        chk("f_latency", cyc, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1);
    end

    initial begin
        int cyc, nf, nd, last_cyc, cnt;
        logic exp_id, prev_ack;

        for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 | (i << 8) | (i ^ 5'h1f);
        rom[3] = 32'h8C01_0004;
        f_req = 0; d_req = 0; f_addr = 0; d_addr = 0; reset = 1'b1;

        // Test 1: reset state, then a single F fetch
        reset_dut();
        chk("rst_busy", busy, 0);
        chk("rst_f_ack", f_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_rom_addr", rom_address, 0);
        chk("rst_count", fetch_count, 0);
        f_addr = 5'd3;
        f_req  = 1'b1;
        fq.push_back(32'h8C01_0004);
        @(posedge clk);
        #1;
        chk("t1_rom_addr", rom_address, 3);
        chk("t1_busy", busy, 1);
        wait_f_ack(10, cyc);
        f_req = 1'b0;
        chk("t1_latency", cyc, 3);
        chk("t1_count", fetch_count, 1);

        // Test 2: both ports held from reset, round-robin starting at F
        f_addr = 5'd1; d_addr = 5'd2;
        for (int i = 0; i < 4; i++) begin
            fq.push_back(rom[1]);
            dq.push_back(rom[2]);
        end
        f_req = 1'b1; d_req = 1'b1;
        reset_dut();
        nf = 0; nd = 0; exp_id = 1'b0; last_cyc = -1; cyc = 0;
        while ((nf < 4 || nd < 4) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (f_ack || d_ack) begin
                chk("t2_order", d_ack, exp_id);
                exp_id = ~exp_id;
                // The other port is eligible during the ack cycle, so no idle bubble appears between grants.
                if (last_cyc >= 0) chk("t2_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                if (f_ack) begin nf++; if (nf == 4) f_req = 1'b0; end
                if (d_ack) begin nd++; if (nd == 4) d_req = 1'b0; end
            end
        end
        chk("t2_done", nf + nd, 8);
        chk("t2_count", fetch_count, 4);

        // Test 3: F held across the ack. The port must not be reissued in the ack cycle.
        @(negedge clk);
        f_addr = 5'd5;
        for (int i = 0; i < 3; i++) fq.push_back(rom[5]);
        f_req = 1'b1;
        nf = 0; last_cyc = -1; cyc = 0; prev_ack = 1'b0;
        while (nf < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (prev_ack) chk("t3_nodup", busy, 0);
            prev_ack = f_ack;
            if (f_ack) begin
                nf++;
                if (last_cyc >= 0) chk("t3_spacing", cyc - last_cyc, 4);
                last_cyc = cyc;
                if (nf == 3) f_req = 1'b0;
            end
        end
        chk("t3_done", nf, 3);
        repeat (6) @(negedge clk);
        chk("t3_idle", busy, 0);
        chk("t3_count", fetch_count, 7);

        // Test 4: address change and req drop during WAIT
        f_addr = 5'd3;
        f_req  = 1'b1;
        fq.push_back(rom[3]);
        @(negedge clk);
        chk("t4_in_wait", busy, 1);
        f_addr = 5'd7;
        f_req  = 1'b0;
        wait_f_ack(10, cyc);
        chk("t4_latency", cyc, 2);
        chk("t4_rom_addr", rom_address, 3);
        chk("t4_count", fetch_count, 8);

        // Test 5: reset during WAIT aborts the transaction
        @(negedge clk);
        f_addr = 5'd4;
        f_req  = 1'b1;
        @(negedge clk);
        chk("t5_in_wait", busy, 1);
        reset = 1'b1;
        f_req = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_f_ack", f_ack, 0);
        chk("t5_f_rdata", f_rdata, 0);
        chk("t5_d_rdata", d_rdata, 0);
        chk("t5_count", fetch_count, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        do_f(5'd6);
        chk("t5_count_after", fetch_count, 1);

        // Test 6: 4-bit fetch counter wraps after 16
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            do_f(5'((i * 3 + 8) % 32));
            if (i == 14) chk("t6_count15", fetch_count, 15);
            if (i == 15) chk("t6_wrap", fetch_count, 0);
        end
        cnt = int'(fetch_count);
        chk("t6_count_final", cnt, 1);

        repeat (4) @(negedge clk);
        chk("fq_empty", fq.size(), 0);
        chk("dq_empty", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
